// File: rtl/vga_pattern_sched.sv
// vga_pattern_sched: frame-synchronous test-pattern scheduler in the vga_clk domain.
// Finds frame boundaries from vsync, serves step/load requests and auto-advance
// only on frame boundaries, and drives pat_sel into the pattern generator.
// Optional feature: define VGA_SCHED_BLANK_EN to insert one black frame before
// every pattern change (default build: blank tied low, changes apply directly).
module vga_pattern_sched #(
  parameter int N_PAT  = 8,
  parameter int PAT_W  = 3,
  parameter int DWELL  = 60,
  parameter int FCNT_W = 16
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              vsync,
  input  logic              auto_en,
  input  logic              step_req,
  output logic              step_ack,
  input  logic              load_req,
  input  logic [PAT_W-1:0]  load_val,
  output logic              load_ack,
  output logic              load_err,
  output logic [PAT_W-1:0]  pat_sel,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              blank
);

  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(N_PAT - 1);
  localparam logic [PAT_W:0]   PAT_LIMIT  = (PAT_W + 1)'(N_PAT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Next pattern index with wrap from the last legal pattern back to zero.
  function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] cur);
    logic [PAT_W-1:0] nxt;
    if (cur == PAT_LAST) begin
      nxt = {PAT_W{1'b0}};
    end else begin
      nxt = cur + PAT_W'(1);
    end
    return nxt;
  endfunction

  state_t              state_q, state_d;
  logic                vsync_d_q;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                frame_tick_q;
  logic                step_ack_q, step_ack_d;
  logic                load_ack_q, load_ack_d;
  logic                load_err_q, load_err_d;
  logic                blank_q, blank_d;

  logic                tick_s;
  logic                run_tick_s;
  logic                eval_s;
  logic                load_ok_s;
  logic                chg_s;
  logic [PAT_W-1:0]    chg_val_s;

`ifdef VGA_SCHED_BLANK_EN
  logic                pend_q, pend_d;
  logic [PAT_W-1:0]    pend_val_q, pend_val_d;
  logic                apply_s;
`endif

  // Rising edge of vsync marks the frame boundary; vsync_d resets high so a
  // vsync already high at reset release does not produce a tick.
  assign tick_s     = vsync & ~vsync_d_q;
  assign run_tick_s = tick_s & (state_q == ST_RUN);
  assign load_ok_s  = ({1'b0, load_val} < PAT_LIMIT);

`ifdef VGA_SCHED_BLANK_EN
  // A tick that ends the blank frame only commits the held change.
  assign apply_s = run_tick_s & pend_q;
  assign eval_s  = run_tick_s & ~pend_q;
`else
  assign eval_s  = run_tick_s;
`endif

  // State sequencing: leave IDLE on the first frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request arbitration on a boundary: load, then step, then auto dwell.
  always_comb begin
    dwell_d    = dwell_q;
    step_ack_d = 1'b0;
    load_ack_d = 1'b0;
    load_err_d = 1'b0;
    chg_s      = 1'b0;
    chg_val_s  = pat_q;
    if (eval_s) begin
      if (load_req) begin
        load_ack_d = 1'b1;
        dwell_d    = {DW_W{1'b0}};
        if (load_ok_s) begin
          chg_s     = 1'b1;
          chg_val_s = load_val;
        end else begin
          load_err_d = 1'b1;
        end
      end else if (step_req) begin
        step_ack_d = 1'b1;
        dwell_d    = {DW_W{1'b0}};
        chg_s      = 1'b1;
        chg_val_s  = next_pat(pat_q);
      end else if (auto_en) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d   = {DW_W{1'b0}};
          chg_s     = 1'b1;
          chg_val_s = next_pat(pat_q);
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end else begin
        dwell_d = dwell_q;
      end
    end else begin
      dwell_d = dwell_q;
    end
  end

  // Pattern update: direct, or deferred by one black frame when enabled.
  always_comb begin
    pat_d = pat_q;
`ifdef VGA_SCHED_BLANK_EN
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    blank_d    = blank_q;
    if (apply_s) begin
      pat_d   = pend_val_q;
      pend_d  = 1'b0;
      blank_d = 1'b0;
    end else if (chg_s) begin
      pend_d     = 1'b1;
      pend_val_d = chg_val_s;
      blank_d    = 1'b1;
    end else begin
      pat_d = pat_q;
    end
`else
    blank_d = 1'b0;
    if (chg_s) begin
      pat_d = chg_val_s;
    end else begin
      pat_d = pat_q;
    end
`endif
  end

  // Free-running frame counter advances on every boundary, IDLE included.
  always_comb begin
    if (tick_s) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      vsync_d_q    <= 1'b1;
      pat_q        <= {PAT_W{1'b0}};
      dwell_q      <= {DW_W{1'b0}};
      frame_cnt_q  <= {FCNT_W{1'b0}};
      frame_tick_q <= 1'b0;
      step_ack_q   <= 1'b0;
      load_ack_q   <= 1'b0;
      load_err_q   <= 1'b0;
      blank_q      <= 1'b0;
`ifdef VGA_SCHED_BLANK_EN
      pend_q       <= 1'b0;
      pend_val_q   <= {PAT_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      vsync_d_q    <= vsync;
      pat_q        <= pat_d;
      dwell_q      <= dwell_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= tick_s;
      step_ack_q   <= step_ack_d;
      load_ack_q   <= load_ack_d;
      load_err_q   <= load_err_d;
      blank_q      <= blank_d;
`ifdef VGA_SCHED_BLANK_EN
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
`endif
    end
  end

  assign pat_sel    = pat_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign step_ack   = step_ack_q;
  assign load_ack   = load_ack_q;
  assign load_err   = load_err_q;
  assign blank      = blank_q;

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Scoreboard bench for vga_pattern_sched (default build, blank feature off).
// Two instances share all stimulus: one with 8 patterns, one with 6, both DWELL=3.
module tb_vga_pattern_sched;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic        vsync;
  logic        auto_en;
  logic        step_req;
  logic        load_req;
  logic [2:0]  load_val;

  logic        a_step_ack, a_load_ack, a_load_err, a_frame_tick, a_blank;
  logic [2:0]  a_pat_sel;
  logic [15:0] a_frame_cnt;
  logic        b_step_ack, b_load_ack, b_load_err, b_frame_tick, b_blank;
  logic [2:0]  b_pat_sel;
  logic [15:0] b_frame_cnt;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_sched #(.N_PAT(8), .PAT_W(3), .DWELL(3), .FCNT_W(16)) dut8 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vsync(vsync), .auto_en(auto_en),
    .step_req(step_req), .step_ack(a_step_ack), .load_req(load_req),
    .load_val(load_val), .load_ack(a_load_ack), .load_err(a_load_err),
    .pat_sel(a_pat_sel), .frame_tick(a_frame_tick), .frame_cnt(a_frame_cnt),
    .blank(a_blank)
  );

  vga_pattern_sched #(.N_PAT(6), .PAT_W(3), .DWELL(3), .FCNT_W(16)) dut6 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vsync(vsync), .auto_en(auto_en),
    .step_req(step_req), .step_ack(b_step_ack), .load_req(load_req),
    .load_val(load_val), .load_ack(b_load_ack), .load_err(b_load_err),
    .pat_sel(b_pat_sel), .frame_tick(b_frame_tick), .frame_cnt(b_frame_cnt),
    .blank(b_blank)
  );

  typedef struct {
    logic [2:0]  p8;
    logic [2:0]  p6;
    logic        sa;
    logic        la;
    logic        e8;
    logic        e6;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       a;
    logic       s;
    logic       l;
    logic [2:0] v;
    logic [2:0] p8;
    logic [2:0] p6;
    logic       sa;
    logic       la;
    logic       e8;
    logic       e6;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic [2:0]  cur8 = 3'd0;
  logic [2:0]  cur6 = 3'd0;
  logic [15:0] cur_cnt = 16'd0;
  logic [15:0] cnt_m = 16'd0;

  // Hand-computed pat_sel per tick for auto mode, DWELL=3, starting after IDLE exit.
  int tab8 [24] = '{0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5,6,6,6,7,7,7,0};
  int tab6 [24] = '{0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5,0,0,0,1,1,1,2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add_vec(input logic a, input logic s, input logic l,
                                  input logic [2:0] v, input logic [2:0] p8,
                                  input logic [2:0] p6, input logic sa, input logic la,
                                  input logic e8, input logic e6);
    vec_t t;
    t.a = a; t.s = s; t.l = l; t.v = v; t.p8 = p8; t.p6 = p6;
    t.sa = sa; t.la = la; t.e8 = e8; t.e6 = e6;
    vecs.push_back(t);
  endfunction

  // One frame: raise requests, push expectation, rising vsync, drop requests after the tick.
  task automatic do_frame(input vec_t vv);
    exp_t e;
    auto_en  = vv.a;
    step_req = vv.s;
    load_req = vv.l;
    load_val = vv.v;
    cnt_m    = cnt_m + 16'd1;
    e.p8 = vv.p8; e.p6 = vv.p6; e.sa = vv.sa; e.la = vv.la;
    e.e8 = vv.e8; e.e6 = vv.e6; e.cnt = cnt_m;
    sb_q.push_back(e);
    repeat (2) @(posedge vga_clk);
    #1 vsync = 1'b1;
    @(posedge vga_clk);
    #1;
    step_req = 1'b0;
    load_req = 1'b0;
    load_val = 3'd0;
    repeat (2) @(posedge vga_clk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
  endtask

  // Monitor: on each frame_tick pop and compare; between ticks outputs must be quiet and stable.
  always @(negedge vga_clk) begin
    if (mon_en) begin
      chk("blank", {31'd0, a_blank | b_blank}, 32'd0);
      if (a_frame_tick === 1'b1) begin
        chk("tick6", {31'd0, b_frame_tick}, 32'd1);
        if (sb_q.size() == 0) begin
          chk("spurious_tick", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pat8", {29'd0, a_pat_sel}, {29'd0, mon_e.p8});
          chk("pat6", {29'd0, b_pat_sel}, {29'd0, mon_e.p6});
          chk("acks", {26'd0, a_step_ack, a_load_ack, b_step_ack, b_load_ack, a_load_err, b_load_err},
                      {26'd0, mon_e.sa, mon_e.la, mon_e.sa, mon_e.la, mon_e.e8, mon_e.e6});
          chk("frame_cnt", {16'd0, a_frame_cnt}, {16'd0, mon_e.cnt});
          chk("frame_cnt6", {16'd0, b_frame_cnt}, {16'd0, mon_e.cnt});
          cur8    = mon_e.p8;
          cur6    = mon_e.p6;
          cur_cnt = mon_e.cnt;
        end
      end else begin
        chk("quiet", {3'd0, a_pat_sel, b_pat_sel, a_step_ack, a_load_ack, a_load_err,
                      b_step_ack, b_load_ack, b_load_err, b_frame_tick, a_frame_cnt},
                     {3'd0, cur8, cur6, 7'd0, cur_cnt});
      end
    end
  end

  // Stimulus: reset with vsync high, directed frame vectors, mid-operation reset.
  initial begin
    sys_rst_n = 1'b0;
    vsync     = 1'b1;
    auto_en   = 1'b0;
    step_req  = 1'b0;
    load_req  = 1'b0;
    load_val  = 3'd0;

    //      a     s     l     v     p8    p6    sa    la    e8    e6
    add_vec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); // IDLE exit
    for (int k = 0; k < 24; k++) begin
      add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'(tab8[k]), 3'(tab6[k]), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0); // dwell 1
    add_vec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0); // frozen
    add_vec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0); // frozen
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0); // dwell 2
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0); // advance
    add_vec(1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1); // load 7
    add_vec(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0); // step wraps 7->0
    add_vec(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0); // load wins
    add_vec(1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); // pending step
    add_vec(1'b0, 1'b0, 1'b1, 3'd6, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1); // load 6 boundary
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); // dwell 1
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); // dwell 2
    add_vec(1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0); // load clears dwell
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 3'd0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0); // step beats auto
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_pat", {26'd0, a_pat_sel, b_pat_sel}, 32'd0);
    chk("rst_cnt", {16'd0, a_frame_cnt}, 32'd0);
    chk("rst_flags", {27'd0, a_step_ack, a_load_ack, a_load_err, a_frame_tick, a_blank}, 32'd0);

    // Release with vsync still high: no tick may appear.
    @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge vga_clk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;

    foreach (vecs[i]) begin
      do_frame(vecs[i]);
    end

    // Reset mid-frame with a step pending: discarded, IDLE exit applies nothing.
    step_req = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1 mon_en = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst2_pat", {26'd0, a_pat_sel, b_pat_sel}, 32'd0);
    chk("rst2_cnt", {16'd0, a_frame_cnt}, 32'd0);
    chk("rst2_flags", {28'd0, a_step_ack, a_load_ack, a_frame_tick, b_step_ack}, 32'd0);
    @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    cur8 = 3'd0;
    cur6 = 3'd0;
    cur_cnt = 16'd0;
    cnt_m = 16'd0;
    mon_en = 1'b1;
    begin
      vec_t t;
      t.a = 1'b0; t.s = 1'b1; t.l = 1'b0; t.v = 3'd0; t.p8 = 3'd0; t.p6 = 3'd0;
      t.sa = 1'b0; t.la = 1'b0; t.e8 = 1'b0; t.e6 = 1'b0;
      do_frame(t);
      t.p8 = 3'd1; t.p6 = 3'd1; t.sa = 1'b1;
      do_frame(t);
    end

    repeat (5) @(posedge vga_clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sched.md
Name: vga_pattern_sched

Overview:
- Frame-synchronous scheduler that decides which test pattern the pixel generator draws.
- Runs in the vga_clk domain, beside the timing controller.
- Observes vsync to find frame boundaries; drives pat_sel into the pattern generator.
- Accepts manual step / direct-load requests over a req/ack handshake and optionally auto-advances after a dwell time; pat_sel changes only at a frame boundary, so no frame is ever torn.

Parameters:
- N_PAT, 8: number of patterns; legal pat_sel range 0..N_PAT-1.
- PAT_W, 3: width of pat_sel / load_val; must satisfy 2^PAT_W >= N_PAT.
- DWELL, 60: frames each pattern is shown in auto mode; legal range >= 1.
- FCNT_W, 16: width of the free-running frame counter.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- vsync  in  1  vertical sync from the timing controller; high during the sync pulse.
- auto_en  in  1  level; 1 = auto-advance every DWELL frames.
- step_req  in  1  request: advance pattern by one; held until step_ack.
- step_ack  out  1  one-cycle pulse when the step is applied.
- load_req  in  1  request: jump to load_val; held until load_ack.
- load_val  in  PAT_W  target pattern; must stay stable while load_req is high.
- load_ack  out  1  one-cycle pulse when the load is applied or rejected.
- load_err  out  1  one-cycle pulse, coincident with load_ack, when load_val >= N_PAT.
- pat_sel  out  PAT_W  current pattern index.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- frame_cnt  out  FCNT_W  frames since reset; wraps at 2^FCNT_W.
- blank  out  1  1 = pixel generator must output black (see Optional Feature).

Behaviour:
- Reset (sys_rst_n=0 at a vga_clk edge) values:
  - pat_sel=0, frame_cnt=0, dwell counter=0.
  - step_ack, load_ack, load_err, frame_tick, blank all 0.
  - vsync_d=1, state=IDLE.
- Reset mid-operation discards pending requests; no ack is issued for them.
- Frame boundary: vsync_d is vsync registered. tick = vsync & ~vsync_d.
  - Because vsync_d resets to 1, a vsync already high at reset release produces no spurious tick.
  - frame_tick is registered: high the cycle after the vsync rising edge is sampled. Latency is 1 cycle from the first vga_clk edge that samples vsync=1.
  - frame_cnt increments on that same cycle.
- States:
  - IDLE: after reset; no pattern change allowed. Go to RUN on the first tick. That tick increments frame_cnt but applies no request.
  - RUN: requests are evaluated only on tick cycles.
- Request evaluation on a tick in RUN, in priority order:
  1. load_req=1:
     - If load_val < N_PAT: pat_sel=load_val.
     - Otherwise: pat_sel unchanged and load_err=1.
     - In both cases load_ack=1 and the dwell counter clears.
  2. Else if step_req=1: pat_sel = (pat_sel==N_PAT-1) ? 0 : pat_sel+1; step_ack=1; the dwell counter clears.
  3. Else if auto_en=1:
     - If dwell == DWELL-1: advance as for a step (no ack) and clear dwell.
     - Otherwise: dwell+1.
  4. Else: hold pat_sel; the dwell counter holds.
- Simultaneous requests:
  - load_req and step_req both high on a tick: only the load is served. step_req stays pending and is served on a later tick.
  - Requests never complete between ticks; ack/err are only ever asserted on a frame_tick cycle.
- All outputs are registered: pat_sel, acks, err and frame_tick update on the same edge.
- Requesters must drop req in the cycle after ack. A req still high one cycle after its ack is treated as a new request at the next tick.
- auto_en deasserted mid-dwell: the dwell counter freezes. Re-asserting resumes the count from the frozen value.
- DWELL=1: advance on every tick.

Optional Feature:
- Macro: VGA_SCHED_BLANK_EN.
- Defined:
  - Every pat_sel change (load, step or auto, but not a rejected load) is preceded by one fully black frame.
  - On the deciding tick: blank=1, the ack is issued, pat_sel is unchanged, and the new value is held internally.
  - On the next tick: pat_sel takes the new value and blank=0.
  - Requests arriving during the blank frame wait for a later tick.
  - The dwell counter does not advance during the blank frame.
- Not defined: blank is tied to 0 and changes apply directly on the deciding tick.

Test Plan:
- Reset release with vsync=1, then vsync falls and rises again -> no frame_tick until the second rising edge; that tick leaves pat_sel=0 and sets frame_cnt=1.
- auto_en=1, DWELL=3, 8 ticks after IDLE exit -> pat_sel 0,0,1,1,1,2,2,2 across successive ticks. With N_PAT=8 and 24 further ticks, the sequence wraps 7->0.
- step_req raised mid-frame at pat_sel=7 -> no change until the next tick. Then pat_sel=0 and step_ack is a 1-cycle pulse coincident with frame_tick.
- load_req with load_val=5 and step_req both high at the same tick -> pat_sel=5 with load_ack only. step_ack arrives at the following tick with pat_sel=6.
- load_val=7 with N_PAT=6 -> load_ack=1 and load_err=1 on the tick; pat_sel unchanged.
- With VGA_SCHED_BLANK_EN: step at pat_sel=2 -> blank=1 for one frame with pat_sel=2, then pat_sel=3 and blank=0. Reset asserted during the blank frame -> pat_sel=0, blank=0, no pending change.
